seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Datapath ALU stage directly downstream of the ALU control decoder. Consumes its 4-bit alucontrol code plus two operands and a shift amount, and produces a registered result and zero flag.
- Every op except MUL completes in one cycle.
- MUL uses an iterative shift-add multiplier with a start/busy/done handshake, so the multicycle controller can stall while it runs.

Parameters:
- WIDTH, 32, operand/result width; MUL iterates exactly WIDTH cycles.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- alucontrol  input  4  operation code from ALU control.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt or immediate).
- shamt  input  SHW  shift amount for SLL/SRL.
- result  output  WIDTH  registered result; held until next completion.
- zero  output  1  registered; 1 iff result==0.
- busy  output  1  high while a MUL is iterating.
- done  output  1  one-cycle pulse when result/zero update.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, zero=1, busy=0, done=0; multiplier registers and counter cleared. Reset mid-MUL aborts the op with no done pulse.
- Op codes:
  - 0010 ADD: a+b, wraps mod 2^WIDTH, no overflow flag.
  - 0110 SUB: a-b, wraps.
  - 0000 AND, 0001 OR, 1100 NOR: bitwise.
  - 0111 SLT: signed a<b gives 1, else 0, zero-extended.
  - 0100 SLTU: unsigned compare, same encoding.
  - 0011 SLL: b<<shamt. 1011 SRL: b>>shamt, logical, zero fill.
  - 1111 MUL: low WIDTH bits of a*b; sign-agnostic.
  - Any other code, including X: result=0, zero=1, done still pulses.
- FSM states: IDLE, MUL, DONE.
  - IDLE + start, non-MUL: result/zero loaded at that edge, next state DONE. done=1 for exactly the following cycle, so latency is 1 cycle.
  - IDLE + start, MUL: acc=0, mcand=a, mplier=b, cnt=0, next state MUL, busy=1 from the next cycle.
  - MUL, each edge: if mplier[0] then acc+=mcand (mod 2^WIDTH); mcand<<=1; mplier>>=1; cnt++. On the edge where cnt==WIDTH-1 the final iteration runs: result=updated acc, zero updated, busy=0, next state DONE.
  - MUL timing: start edge E0, done high in the cycle after edge E(WIDTH), busy high during cycles E0..E(WIDTH-1).
  - DONE: done=1 for one cycle. start is accepted in DONE exactly as in IDLE, so back-to-back ops need no bubble. Otherwise return to IDLE.
- start while busy=1: ignored, no queuing. Input changes during MUL have no effect; operands are captured at E0.
- done and busy are never simultaneously 1.
- result/zero change only on a completion edge; otherwise they hold.

Test Plan:
- Reset then idle → result=0, zero=1, busy=0, done=0. Assert rst_n low asynchronously mid-cycle → outputs clear immediately.
- ADD a=0xFFFFFFFF, b=1 → next cycle done=1, result=0, zero=1. SUB 5-7 → 0xFFFFFFFE. SLT a=0xFFFFFFFF, b=1 → 1. SLTU, same operands → 0.
- SLL b=0x1, shamt=31 → 0x80000000. SRL b=0x80000000, shamt=31 → 0x1. NOR 0,0 → 0xFFFFFFFF.
- MUL a=12345, b=6789 → busy for 32 cycles, done in the 33rd cycle after start, result=83810205. MUL 0x10000 × 0x10000 → result=0, zero=1.
- start pulsed, and operands changed, during MUL → ignored and first result unaffected. ADD issued in the MUL done cycle → accepted, done pulses again on the very next cycle.
- rst_n low at iteration 10 of a MUL → no done, busy=0, result=0. A fresh MUL afterwards completes correctly.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//
// ALU stage that sits directly after the ALU control decoder. Most operations
// finish in one cycle. MUL runs on an iterative shift-add multiplier that takes
// exactly WIDTH cycles. While it runs, busy is high so the multicycle
// controller can stall.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       operation request; only taken when busy is low
//   alucontrol  4-bit operation code
//   a, b        operands (rs, rt/immediate)
//   shamt       shift amount for SLL/SRL
//   result      registered result, held until the next completion
//   zero        registered, 1 iff result == 0
//   busy        high while a MUL is iterating
//   done        one-cycle pulse on the cycle after result/zero update
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    // Multiplier working registers
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_is_mul;
    logic             w_slt;
    logic             w_sltu;

    assign w_slt  = $signed(a) < $signed(b);
    assign w_sltu = a < b;

    // Single-cycle datapath. An unknown or unused code gives 0. Because of
    // that, a garbage code still completes cleanly with zero=1.
    always_comb begin
        w_alu_res = '0;
        case (alucontrol)
            OP_ADD:  w_alu_res = a + b;
            OP_SUB:  w_alu_res = a - b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_NOR:  w_alu_res = ~(a | b);
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, w_sltu};
            OP_SLL:  w_alu_res = b << shamt;
            OP_SRL:  w_alu_res = b >> shamt;
            default: w_alu_res = '0;
        endcase
    end

    // A code containing X does not match, so it falls through to the
    // single-cycle path and never starts the multiplier.
    assign w_is_mul = (alucontrol == OP_MUL);

    // One shift-add step. The low WIDTH bits of the product do not depend on
    // whether the operands are signed, so no sign handling is needed.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a new request the same way IDLE does. This lets
                // back-to-back operations run without a bubble cycle.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (w_is_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == '0);
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                // start is ignored here. The operands were captured at the
                // start edge, so later input changes have no effect.
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_acc_next;
                        r_zero   <= (w_acc_next == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//
// Scoreboard bench for seq_alu. Each accepted request pushes the result that a
// plain-arithmetic reference model predicts. A separate monitor pops one entry
// per done pulse and compares it with result/zero.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    alucontrol = 4'b0000;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [4:0]    shamt = '0;
    logic [W-1:0]  result;
    logic          zero;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic [3:0]  op;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_res = '0;

    seq_alu #(.WIDTH(W), .SHW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .result     (result),
        .zero       (zero),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: the behaviour of each operation in plain arithmetic.
    function automatic logic [31:0] ref_model(logic [3:0] op, logic [31:0] x,
                                              logic [31:0] y, logic [4:0] s);
        logic [63:0] p;
        case (op)
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b1100: return ~(x | y);
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0100: return (x < y) ? 32'd1 : 32'd0;
            4'b0011: return y << s;
            4'b1011: return y >> s;
            4'b1111: begin
                p = {32'd0, x} * {32'd0, y};
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a request at the current time. Only record an expectation if the
    // DUT will actually take it (not busy).
    task automatic drive_now(logic [3:0] op, logic [31:0] x, logic [31:0] y,
                             logic [4:0] s);
        exp_t e;
        alucontrol = op;
        a          = x;
        b          = y;
        shamt      = s;
        start      = 1'b1;
        if (!busy) begin
            e.res = ref_model(op, x, y, s);
            e.z   = (e.res == 32'd0);
            e.op  = op;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue(logic [3:0] op, logic [31:0] x, logic [31:0] y,
                         logic [4:0] s);
        @(negedge clk);
        drive_now(op, x, y, s);
    endtask

    // Waits (bounded) for done. Returns at the negedge where done is seen.
    task automatic wait_done(string name, int maxc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", name, maxc);
        end
    endtask

    task automatic run_dir(string name, logic [3:0] op, logic [31:0] x,
                           logic [31:0] y, logic [4:0] s, logic [31:0] expv,
                           logic expz);
        issue(op, x, y, s);
        wait_done(name, 40);
        chk(name, result, expv);
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, expz});
    endtask

    // Monitor: pop and compare on every done. Between completions, result must
    // hold, and done and busy must never be high together.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res <= '0;
        end else begin
            if (done && busy) begin
                n_err++;
                $display("FAIL done_busy_overlap: done=%b busy=%b, required not both 1", done, busy);
            end
            if (done) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: result=%h, no request outstanding", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (result !== e.res || zero !== e.z) begin
                        n_err++;
                        $display("FAIL sb_op%b: got result=%h zero=%b, expected result=%h zero=%b",
                                 e.op, result, zero, e.res, e.z);
                    end else begin
                        $display("op=%b result=%h zero=%b ok", e.op, result, zero);
                    end
                end
                last_res <= result;
            end else if (result !== last_res) begin
                n_err++;
                $display("FAIL result_hold: got %h, expected held %h", result, last_res);
            end
        end
    end

    initial begin : stim
        logic [3:0] ops [12];
        int         k;
        int         busy_cnt;
        int         done_cnt;
        ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111,
                4'b0100, 4'b0011, 4'b1011, 4'b1111, 4'b0101, 4'b1000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_result", result, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);

        // Directed single-cycle ops
        run_dir("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1);
        run_dir("sub", 4'b0110, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0);
        run_dir("slt", 4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0);
        run_dir("sltu", 4'b0100, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1);
        run_dir("sll31", 4'b0011, 32'd0, 32'd1, 5'd31, 32'h80000000, 1'b0);
        run_dir("srl31", 4'b1011, 32'd0, 32'h80000000, 5'd31, 32'd1, 1'b0);
        run_dir("nor0", 4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
        run_dir("badop", 4'b1001, 32'h1234, 32'h5678, 5'd3, 32'd0, 1'b1);

        // MUL latency: busy for 32 cycles, done in the 33rd cycle
        issue(4'b1111, 32'd12345, 32'd6789, 5'd0);
        k = 0;
        busy_cnt = 0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        chk("mul_busy_cycles", busy_cnt, 32'd32);
        chk("mul_done_cycle", k, 32'd33);
        chk("mul_result", result, 32'd83810205);

        // Back-to-back: ADD issued in the MUL done cycle
        drive_now(4'b0010, 32'd100, 32'd23, 5'd0);
        wait_done("b2b_add", 1);
        chk("b2b_add_result", result, 32'd123);

        run_dir("mul_ovf_zero", 4'b1111, 32'h10000, 32'h10000, 5'd0, 32'd0, 1'b1);

        // start and operand changes during MUL are ignored
        issue(4'b1111, 32'd1000, 32'd77, 5'd0);
        repeat (3) @(negedge clk);
        drive_now(4'b0010, 32'd5, 32'd5, 5'd0);
        a = 32'hDEADBEEF;
        b = 32'h0BADF00D;
        wait_done("mul_ignore", 40);
        chk("mul_ignore_result", result, 32'd77000);

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        run_dir("pre_rst_add", 4'b0010, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_zero", {31'd0, zero}, 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset at iteration 10 of a MUL aborts it
        issue(4'b1111, 32'hABCDEF, 32'h12345, 5'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 32'd0);
        run_dir("fresh_mul", 4'b1111, 32'd65535, 32'd65537, 5'd0, 32'hFFFFFFFF, 1'b0);

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] x;
            logic [31:0] y;
            op = ops[$urandom_range(0, 11)];
            x  = $urandom();
            y  = $urandom();
            if ($urandom_range(0, 3) == 0) x = x & 32'hF;
            if ($urandom_range(0, 3) == 0) y = x;
            issue(op, x, y, 5'($urandom_range(0, 31)));
            wait_done("rand", 40);
        end

        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute guard so the bench cannot hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
